// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter
//   Sequencer/arbiter for a 256x32-write / 512x16-read simple dual-port RAM.
//   After reset it writes CLR_VALUE to every entry (CLEAR). In RUN it drains a
//   2-entry write FIFO to the write port and shares the read port between two
//   clients round-robin, forwarding from queued writes so reads are never stale.
// Ports
//   clk, reset_n           : clock, async active-low reset
//   init_done              : clear sequence finished
//   wr_valid/ready/addr/data : buffered 32-bit write interface
//   rd_req*/rd_addr*       : read requests, 16-bit word address
//   rd_gnt*                : combinational grant
//   rd_valid*, rd_data     : read response, 1 cycle after grant (shared data)
//   ram_cea/ada/din        : RAM write port
//   ram_ceb/adb/oce/dout   : RAM read port (bypass mode)
module regfile_port_arbiter #(
  parameter logic [31:0] CLR_VALUE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        init_done,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [7:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        rd_req0,
  input  logic        rd_req1,
  input  logic [8:0]  rd_addr0,
  input  logic [8:0]  rd_addr1,
  output logic        rd_gnt0,
  output logic        rd_gnt1,
  output logic        rd_valid0,
  output logic        rd_valid1,
  output logic [15:0] rd_data,
  output logic        ram_cea,
  output logic [7:0]  ram_ada,
  output logic [31:0] ram_din,
  output logic        ram_ceb,
  output logic [8:0]  ram_adb,
  output logic        ram_oce,
  input  logic [15:0] ram_dout
);

  localparam logic ST_CLEAR = 1'b0;
  localparam logic ST_RUN   = 1'b1;

  logic        state;
  logic [7:0]  clr_cnt;

  // FIFO entry 0 is the head (oldest), entry 1 the younger one.
  logic [1:0]  cnt;
  logic [7:0]  fa0, fa1;
  logic [31:0] fd0, fd1;

  logic        prio1;      // 1: client 1 wins a tie
  logic        fwd_q;
  logic [15:0] fwd_data_q;
  logic [15:0] hold_q;

  logic        run, push, pop;
  logic [8:0]  gnt_addr;
  logic        m0, m1;
  logic [31:0] fwd_word;
  logic [15:0] fwd_half;

  assign run       = (state == ST_RUN);
  assign init_done = run;
  assign wr_ready  = run && (cnt != 2'd2);
  assign push      = wr_valid && wr_ready;
  assign pop       = (cnt != 2'd0);

  // Write port: clear sweep, else FIFO head. Gated by reset_n so the write
  // port is quiet while reset is held even though CLEAR is the reset state.
  assign ram_cea = reset_n && (!run || pop);
  assign ram_ada = run ? fa0 : clr_cnt;
  assign ram_din = run ? fd0 : CLR_VALUE;
  assign ram_oce = 1'b1;

  // Round-robin: single requester wins outright, ties go to prio.
  assign rd_gnt0  = run && rd_req0 && (!rd_req1 || !prio1);
  assign rd_gnt1  = run && rd_req1 && (!rd_req0 ||  prio1);
  assign gnt_addr = rd_gnt1 ? rd_addr1 : rd_addr0;
  assign ram_ceb  = rd_gnt0 || rd_gnt1;
  assign ram_adb  = ram_ceb ? gnt_addr : 9'd0;

  // Forward from queued writes, head included (it hits the RAM only at the
  // end of this cycle, too late for the bypass-mode read). Youngest wins.
  assign m0       = (cnt != 2'd0) && (fa0 == gnt_addr[8:1]);
  assign m1       = (cnt == 2'd2) && (fa1 == gnt_addr[8:1]);
  assign fwd_word = m1 ? fd1 : fd0;
  assign fwd_half = gnt_addr[0] ? fwd_word[31:16] : fwd_word[15:0];

  assign rd_data = (rd_valid0 || rd_valid1) ? (fwd_q ? fwd_data_q : ram_dout) : hold_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_CLEAR;
      clr_cnt <= 8'd0;
    end else if (!run) begin
      clr_cnt <= clr_cnt + 8'd1;
      if (clr_cnt == 8'hFF) state <= ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= 2'd0;
      fa0 <= 8'd0;  fa1 <= 8'd0;
      fd0 <= 32'd0; fd1 <= 32'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) begin fa0 <= wr_addr; fd0 <= wr_data; end
          else             begin fa1 <= wr_addr; fd1 <= wr_data; end
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          fa0 <= fa1; fd0 <= fd1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            fa0 <= wr_addr; fd0 <= wr_data;
          end else begin
            fa0 <= fa1; fd0 <= fd1;
            fa1 <= wr_addr; fd1 <= wr_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio1      <= 1'b0;
      rd_valid0  <= 1'b0;
      rd_valid1  <= 1'b0;
      fwd_q      <= 1'b0;
      fwd_data_q <= 16'd0;
      hold_q     <= 16'd0;
    end else begin
      if (rd_gnt0) prio1 <= 1'b1;
      if (rd_gnt1) prio1 <= 1'b0;
      rd_valid0 <= rd_gnt0;
      rd_valid1 <= rd_gnt1;
      fwd_q     <= ram_ceb && (m0 || m1);
      if (ram_ceb) fwd_data_q <= fwd_half;
      if (rd_valid0 || rd_valid1) hold_q <= rd_data;
    end
  end

endmodule
